// File: rtl/chroma_supersample_4x4.sv
// rtl/chroma_supersample_4x4.sv - 4x4 to 8x8 chroma upsampler by 2x2 nearest-neighbour replication
// One register stage: the 4x4 block is captured on valid_in and fanned out to the 8x8 view.
module chroma_supersample_4x4 #(
  parameter  int CH = 3,
  parameter  int W  = 9,
  localparam int CW = $clog2(CH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CW-1:0]              ch,
  input  logic                       valid_in,
  input  logic [3:0][3:0][W-1:0]     block_in,
  output logic [7:0][7:0][W-1:0]     block_out,
  output logic [CW-1:0]              ch_out,
  output logic                       valid_out
);

  logic [3:0][3:0][W-1:0] r_blk;
  logic [CW-1:0]          r_ch;
  logic                   r_valid;

  // Data only loads on valid_in so idle-cycle garbage (including X) never reaches the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blk   <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_blk <= block_in;
        r_ch  <= ch;
      end
    end
  end

  // Replication is pure wiring, so only the 16 source samples need storage.
  for (genvar g_r = 0; g_r < 8; g_r++) begin : g_row
    for (genvar g_c = 0; g_c < 8; g_c++) begin : g_col
      assign block_out[g_r][g_c] = r_blk[g_r/2][g_c/2];
    end
  end

  assign ch_out    = r_ch;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_chroma_supersample_4x4.sv
// tb/tb_chroma_supersample_4x4.sv - randomized and directed check of chroma_supersample_4x4
// Reference: an 8x8 array filled from the last accepted 4x4 input by integer division of indices.
module tb_chroma_supersample_4x4;

  logic                   clock;
  logic                   reset;
  logic [1:0]             ch;
  logic                   valid_in;
  logic [3:0][3:0][8:0]   block_in;
  logic [7:0][7:0][8:0]   block_out;
  logic [1:0]             ch_out;
  logic                   valid_out;

  int total = 0;
  int bad   = 0;

  logic [8:0] m_blk [8][8];
  logic [1:0] m_ch;
  logic       m_valid;

  chroma_supersample_4x4 #(.CH(3), .W(9)) dut (
    .clock     (clock),
    .reset     (reset),
    .ch        (ch),
    .valid_in  (valid_in),
    .block_in  (block_in),
    .block_out (block_out),
    .ch_out    (ch_out),
    .valid_out (valid_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ch    = 2'b00;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m_blk[r][c] = 9'h000;
  endtask

  // Advance one edge, updating the model from what the bench drove, then step off the edge.
  task automatic cycle();
    @(posedge clock);
    m_valid = valid_in;
    if (valid_in) begin
      m_ch = ch;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          m_blk[r][c] = block_in[r/2][c/2];
    end
    #1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".ch"}, 32'(ch_out), 32'(m_ch));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s.blk[%0d][%0d]", tag, r, c), 32'(block_out[r][c]), 32'(m_blk[r][c]));
  endtask

  task automatic load_pattern(input int offset);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        block_in[i][j] = 9'(1 + 4*(3-i) + (3-j) + offset);
  endtask

  task automatic fill(input logic [8:0] v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        block_in[i][j] = v;
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    ch       = 2'b00;
    block_in = '0;
    model_reset();

    // Reset with no clock edge
    #1 reset = 1'b1;
    #1;
    check_outputs("reset");
    #1 reset = 1'b0;
    cycle(); check_outputs("idle0");
    cycle(); check_outputs("idle1");

    // Single block on Cb
    load_pattern(0); ch = 2'b01; valid_in = 1'b1;
    cycle();
    valid_in = 1'b0;
    check_outputs("single");
    chk("single.v",    32'(valid_out), 32'd1);
    chk("single.ch",   32'(ch_out), 32'd1);
    chk("single.77",   32'(block_out[7][7]), 32'd1);
    chk("single.76",   32'(block_out[7][6]), 32'd1);
    chk("single.67",   32'(block_out[6][7]), 32'd1);
    chk("single.66",   32'(block_out[6][6]), 32'd1);
    chk("single.75",   32'(block_out[7][5]), 32'd2);
    chk("single.57",   32'(block_out[5][7]), 32'd5);
    chk("single.00",   32'(block_out[0][0]), 32'd16);
    chk("single.11",   32'(block_out[1][1]), 32'd16);
    cycle();
    check_outputs("single_hold");
    chk("single_hold.v", 32'(valid_out), 32'd0);

    // Back-to-back blocks
    load_pattern(0); valid_in = 1'b1;
    cycle();
    chk("b2b0.v",  32'(valid_out), 32'd1);
    chk("b2b0.77", 32'(block_out[7][7]), 32'd1);
    chk("b2b0.00", 32'(block_out[0][0]), 32'd16);
    load_pattern(1);
    cycle();
    valid_in = 1'b0;
    chk("b2b1.v",  32'(valid_out), 32'd1);
    chk("b2b1.77", 32'(block_out[7][7]), 32'd2);
    chk("b2b1.00", 32'(block_out[0][0]), 32'd17);
    check_outputs("b2b1");

    // Hold with changed input, then X input while idle
    fill(9'h1FF);
    cycle();
    check_outputs("hold");
    chk("hold.77", 32'(block_out[7][7]), 32'd2);
    block_in = 'x;
    cycle();
    check_outputs("xidle");

    // Channel pass-through
    fill(9'h100); ch = 2'b10; valid_in = 1'b1;
    cycle();
    valid_in = 1'b0;
    check_outputs("chpass");
    chk("chpass.ch", 32'(ch_out), 32'd2);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("chpass.k[%0d][%0d]", r, c), 32'(block_out[r][c]), 32'h100);

    // Randomized traffic, all ch codes
    for (int n = 0; n < 200; n++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ch = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          block_in[i][j] = 9'($urandom_range(0, 511));
      cycle();
      check_outputs($sformatf("rand%0d", n));
    end

    // Async reset between edges right after a valid block
    load_pattern(7); ch = 2'b11; valid_in = 1'b1;
    cycle();
    valid_in = 1'b0;
    chk("pre_rst.v", 32'(valid_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    #2 reset = 1'b0;
    cycle();
    check_outputs("post_rst_idle");
    load_pattern(3); ch = 2'b01; valid_in = 1'b1;
    cycle();
    valid_in = 1'b0;
    check_outputs("post_rst_blk");
    chk("post_rst.77", 32'(block_out[7][7]), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
